// File: rtl/usb_tx_pkg.sv
// Shared types and line-state constants for the USB full-speed
// transmit encoder: FSM states, {d_plus,d_minus} codes, default SYNC.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_PAT_DEF = 8'h80;

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake into the USB transmit encoder.
// master: source drives data/valid/last; slave: encoder drives ready.
interface usb_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready
  );

endinterface

// File: rtl/usb_tx_encoder_nrzi.sv
// NRZI line driver with bit stuffing. Ports: bit_stb starts a new bit,
// bit_vld/bit_in give the data bit, line is {d_plus,d_minus}, stuff_req.
module usb_nrzi_stuffer
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_stb,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic [1:0] line,
  output logic       stuff_req
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] ONES_MAX = CW'(STUFF_LEN);

  logic [CW-1:0] ones_cnt;

  // A full run of ones means the next bit is a stuffed 0,
  // so the caller must hold its data bit for one more bit time.
  assign stuff_req = (ones_cnt == ONES_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line     <= LINE_J;
      ones_cnt <= '0;
    end else if (bit_stb) begin
      if (!bit_vld) begin
        line     <= LINE_J;
        ones_cnt <= '0;
      end else if (stuff_req || !bit_in) begin
        line     <= ~line;
        ones_cnt <= '0;
      end else begin
        ones_cnt <= ones_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB FS transmit encoder: SYNC, NRZI/stuffed data, EOP. Ports: clk,
// n_rst, bus (slave), tx_d_plus/minus, is_txing, underrun, stuff_cnt.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              CLKS_PER_BIT = 8,
  parameter int              STUFF_LEN    = 6,
  parameter logic [DATA_W-1:0] SYNC_PAT   = DATA_W'(SYNC_PAT_DEF),
  parameter int              EOP_SE0_BITS = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  usb_tx_if.slave     bus,
  output logic        tx_d_plus,
  output logic        tx_d_minus,
  output logic        is_txing,
  output logic        underrun,
  output logic [15:0] stuff_cnt
);

  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LEFT_MAX = BW'(DATA_W - 1);
  localparam logic [EW-1:0] EOP_MAX  = EW'(EOP_SE0_BITS - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q;
  logic [DATA_W-1:0] sr_q;
  logic [BW-1:0]     left_q;
  logic              last_q;
  logic [EW-1:0]     eop_q;

  logic       start, bit_end, in_word;
  logic       word_end, load_slot, load;
  logic       bit_stb, bit_vld, bit_in;
  logic       stuff_req;
  logic [1:0] nrzi_line, line;

  assign in_word   = (state_q == SYNC) || (state_q == DATA);
  assign start     = (state_q == IDLE) && bus.tx_valid;
  assign bit_end   = (state_q != IDLE) && (div_q == DIV_MAX);
  // Word boundary: no bits left and no stuffed bit pending.
  assign word_end  = in_word && bit_end && !stuff_req && (left_q == '0);
  assign load_slot = word_end && !((state_q == DATA) && last_q);
  assign load      = load_slot && bus.tx_valid;
  assign bus.tx_ready = load;

  assign bit_stb = start || bit_end;
  assign bit_vld = start || (in_word && !(word_end && !load));
  assign bit_in  = start          ? SYNC_PAT[0] :
                   (left_q != '0) ? sr_q[0]     :
                                    bus.tx_data[0];

  usb_nrzi_stuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi (
    .clk       (clk),
    .n_rst     (n_rst),
    .bit_stb   (bit_stb),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .line      (nrzi_line),
    .stuff_req (stuff_req)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SYNC;
      SYNC,
      DATA:    if (word_end) state_d = load ? DATA : EOP_SE0;
      EOP_SE0: if (bit_end && eop_q == EOP_MAX) state_d = EOP_J;
      EOP_J:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      sr_q      <= '0;
      left_q    <= '0;
      last_q    <= 1'b0;
      eop_q     <= '0;
      underrun  <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start || bit_end) div_q <= '0;
      else if (state_q != IDLE) div_q <= div_q + 1'b1;
      if (start) begin
        sr_q   <= SYNC_PAT >> 1;
        left_q <= LEFT_MAX;
        last_q <= 1'b0;
      end else if (load) begin
        sr_q   <= bus.tx_data >> 1;
        left_q <= LEFT_MAX;
        last_q <= bus.tx_last;
      end else if (in_word && bit_end && !stuff_req && left_q != '0) begin
        sr_q   <= sr_q >> 1;
        left_q <= left_q - 1'b1;
      end
      if (word_end && !load) eop_q <= '0;
      else if (state_q == EOP_SE0 && bit_end) eop_q <= eop_q + 1'b1;
      if (start) underrun <= 1'b0;
      else if (load_slot && !bus.tx_valid) underrun <= 1'b1;
      if (start) stuff_cnt <= '0;
      else if (in_word && bit_end && stuff_req && stuff_cnt != 16'hFFFF)
        stuff_cnt <= stuff_cnt + 1'b1;
    end
  end

  always_comb begin
    line = nrzi_line;
    case (state_q)
      IDLE, EOP_J: line = LINE_J;
      EOP_SE0:     line = LINE_SE0;
      default:     line = nrzi_line;
    endcase
  end

  assign {tx_d_plus, tx_d_minus} = line;
  assign is_txing = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomized self-checking bench for usb_tx_encoder against a
// bit-list reference model (SYNC+data, stuffing, NRZI, EOP).
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam int SL  = 6;
  localparam int NE  = 2;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LSE = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_tx_if #(.DATA_W(8)) bus ();

  logic        dp, dm, txing, ur;
  logic [15:0] sc;

  usb_tx_encoder dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .tx_d_plus  (dp),
    .tx_d_minus (dm),
    .is_txing   (txing),
    .underrun   (ur),
    .stuff_cnt  (sc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] exp_line[$];
  int         exp_rdy[$];
  int         exp_stuff;
  logic [1:0] obs[$];
  int         rdy[$];

  // Reference: bit list -> stuffing -> NRZI, one entry per bit time.
  task automatic model(input logic [7:0] w[$]);
    logic [7:0] s;
    logic [1:0] ln;
    int         ones;
    logic       b;
    exp_line.delete();
    exp_rdy.delete();
    exp_stuff = 0;
    s = 8'h80;
    ln = LJ;
    ones = 0;
    for (int i = 0; i < 8 + 8 * w.size(); i++) begin
      if (i < 8) b = s[i];
      else b = w[(i-8)/8][(i-8)%8];
      if (i >= 8 && (i - 8) % 8 == 0)
        exp_rdy.push_back(exp_line.size() * CPB - 1);
      if (b == 1'b0) begin
        ln = (ln == LJ) ? LK : LJ;
        ones = 0;
      end else begin
        ones++;
      end
      exp_line.push_back(ln);
      if (ones == SL) begin
        ln = (ln == LJ) ? LK : LJ;
        ones = 0;
        exp_stuff++;
        exp_line.push_back(ln);
      end
    end
    for (int i = 0; i < NE; i++) exp_line.push_back(LSE);
    exp_line.push_back(LJ);
  endtask

  task automatic drive(input logic [7:0] w[$], input bit urm,
                       input string name);
    int n;
    for (int i = 0; i < w.size(); i++) begin
      bus.tx_data  = w[i];
      bus.tx_last  = (i == w.size() - 1) && !urm;
      bus.tx_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.tx_ready && n < 500);
      if (!bus.tx_ready) begin
        chk({name, "_ready_timeout"}, 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
  endtask

  task automatic monitor(input string name);
    int cyc;
    obs.delete();
    rdy.delete();
    @(negedge clk);
    chk({name, "_pre_start"}, txing, 0);
    @(negedge clk);
    chk({name, "_start"}, txing, 1);
    chk({name, "_ur_clear"}, ur, 0);
    cyc = 0;
    while (txing && cyc < 3000) begin
      obs.push_back({dp, dm});
      if (bus.tx_ready) rdy.push_back(cyc);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_packet(input logic [7:0] w[$], input bit urm,
                            input string name);
    logic [1:0] v;
    bit         same;
    int         nb;
    model(w);
    fork
      drive(w, urm, name);
      monitor(name);
    join
    chk({name, "_txing_len"}, obs.size(), exp_line.size() * CPB);
    nb = obs.size() / CPB;
    if (nb > exp_line.size()) nb = exp_line.size();
    for (int b = 0; b < nb; b++) begin
      v = obs[b*CPB];
      same = 1'b1;
      for (int k = 1; k < CPB; k++)
        if (obs[b*CPB+k] !== v) same = 1'b0;
      chk($sformatf("%s_bit%0d", name, b), same ? v : 2'bxx,
          exp_line[b]);
    end
    chk({name, "_ready_cnt"}, rdy.size(), exp_rdy.size());
    for (int i = 0; i < rdy.size() && i < exp_rdy.size(); i++)
      chk($sformatf("%s_ready%0d_cyc", name, i), rdy[i], exp_rdy[i]);
    chk({name, "_stuff_cnt"}, sc, exp_stuff);
    chk({name, "_underrun"}, ur, urm);
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    chk({name, "_idle_line"}, {dp, dm, txing}, {LJ, 1'b0});
    chk({name, "_ur_sticky"}, ur, urm);
  endtask

  logic [7:0] w[$];
  int         n;

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), {dp, dm, txing, bus.tx_ready, ur, sc},
          {LJ, 3'b000, 16'h0});
    end
    @(posedge clk);
    #1;

    w = '{8'h00};
    run_packet(w, 1'b0, "w00");
    w = '{8'hFF};
    run_packet(w, 1'b0, "wFF");
    w = '{8'hA5, 8'h3C, 8'h0F};
    run_packet(w, 1'b0, "b2b");
    w = '{8'h12};
    run_packet(w, 1'b1, "urun");

    // Reset during the second data bit.
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b1;
    bus.tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!txing && n < 10);
    chk("rst_mid_started", txing, 1);
    repeat (75) @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("rst_mid_line", {dp, dm, txing}, {LJ, 1'b0});
    chk("rst_mid_ready", bus.tx_ready, 0);
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    w = '{8'h00};
    run_packet(w, 1'b0, "post_rst");

    for (int p = 0; p < 8; p++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(1, 3); i++)
        w.push_back(($urandom_range(0, 3) == 0) ? 8'hFF :
                    8'($urandom));
      run_packet(w, ($urandom_range(0, 3) == 0),
                 $sformatf("rnd%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
